// File: rtl/imem_loader.sv
// Byte-stream program loader: frames N, 4*N big-endian data bytes, XOR checksum into instruction memory.
// One write cycle per assembled word (byte_ready drops for that cycle); core held in reset until load verified.
module imem_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        S_HDR,
        S_LOAD,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state, state_next;
    logic [1:0]        byte_cnt;
    logic [ADDR_W:0]   n_words;
    logic [7:0]        csum;
    logic [7:0]        chk_byte;
    logic [31:0]       word;
    logic              xfer;
    logic              at_chksum;
    logic              hdr_bad;

    assign xfer      = byte_valid & byte_ready;
    // Once all N words are written, the next byte in LOAD is the checksum, not data.
    assign at_chksum = (word_count == n_words);
    assign hdr_bad   = int'(byte_data) > DEPTH;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_HDR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        cpu_hold   = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            S_HDR: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    state_next = hdr_bad ? S_ERR : S_LOAD;
                end
            end
            S_LOAD: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    if (at_chksum) begin
                        state_next = S_CHK;
                    end else if (byte_cnt == 2'd3) begin
                        state_next = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                mem_we     = 1'b1;
                mem_addr   = word_count[ADDR_W-1:0];
                mem_wdata  = word;
                state_next = S_LOAD;
            end
            S_CHK: begin
                state_next = (chk_byte == csum) ? S_DONE : S_ERR;
            end
            S_DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
            end
            S_ERR: begin
                error = 1'b1;
            end
            default: begin
                state_next = S_HDR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt   <= '0;
            word_count <= '0;
            n_words    <= '0;
            csum       <= '0;
            chk_byte   <= '0;
            word       <= '0;
        end else begin
            if (xfer && state == S_HDR) begin
                n_words <= (ADDR_W+1)'(byte_data);
            end
            if (xfer && state == S_LOAD) begin
                if (at_chksum) begin
                    chk_byte <= byte_data;
                end else begin
                    word     <= {word[23:0], byte_data};
                    csum     <= csum ^ byte_data;
                    byte_cnt <= byte_cnt + 2'd1;
                end
            end
            if (state == S_WRITE) begin
                word_count <= word_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized frames for imem_loader, scored against a frame-parsing reference model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [5:0]  word_count;

    imem_loader #(.ADDR_W(5), .DEPTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int both_cnt = 0;

    logic [7:0]  frame[$];
    logic [31:0] words[$];
    int          acc_cyc[$];
    logic [4:0]  wq_a[$];
    logic [31:0] wq_d[$];
    int          wq_c[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Write-port monitor: records every write and the cycle it occurs in.
    always @(negedge clk) begin
        if (mem_we) begin
            wq_a.push_back(mem_addr);
            wq_d.push_back(mem_wdata);
            wq_c.push_back(cyc);
        end
        if (done && error) both_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input int budget, output bit ok);
        bit rdy;
        ok = 1'b0;
        byte_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            rdy = byte_ready;
            if (rdy) acc_cyc.push_back(cyc);
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, byte_ready, 1'b1);
        check({tag, "_we"},    mem_we,     1'b0);
        check({tag, "_addr"},  mem_addr,   5'd0);
        check({tag, "_wdata"}, mem_wdata,  32'd0);
        check({tag, "_hold"},  cpu_hold,   1'b1);
        check({tag, "_done"},  done,       1'b0);
        check({tag, "_error"}, error,      1'b0);
        check({tag, "_wcnt"},  word_count, 6'd0);
    endtask

    task automatic build_frame(input logic [7:0] corrupt);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        frame.delete();
        frame.push_back(8'(words.size()));
        foreach (words[i]) begin
            for (int k = 3; k >= 0; k--) begin
                b = words[i][8*k +: 8];
                frame.push_back(b);
                x ^= b;
            end
        end
        frame.push_back(x ^ corrupt);
    endtask

    // Sends the frame in 'frame', then compares against what the frame rules predict.
    task automatic run_frame(input string tag, input int max_gap);
        int          n;
        bit          hdr_bad;
        int          nsend;
        bit          ok;
        logic [7:0]  x;
        logic [31:0] w;
        bit          exp_done;
        logic [31:0] exp_words[$];

        n       = int'(frame[0]);
        hdr_bad = (n > 32);
        nsend   = hdr_bad ? 1 : frame.size();
        exp_words.delete();
        x = 8'h00;
        if (!hdr_bad) begin
            for (int i = 0; i < n; i++) begin
                w = {frame[1+4*i], frame[2+4*i], frame[3+4*i], frame[4+4*i]};
                exp_words.push_back(w);
                x = x ^ frame[1+4*i] ^ frame[2+4*i] ^ frame[3+4*i] ^ frame[4+4*i];
            end
        end
        exp_done = !hdr_bad && (frame[4*n+1] == x);

        wq_a.delete(); wq_d.delete(); wq_c.delete(); acc_cyc.delete();
        for (int i = 0; i < nsend; i++) begin
            send_byte(frame[i], $urandom_range(0, max_gap), 40, ok);
            if (!ok) begin
                check({tag, "_accept"}, ok, 1'b1);
                break;
            end
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end

        check({tag, "_nwrites"}, wq_a.size(), exp_words.size());
        for (int i = 0; i < exp_words.size() && i < wq_a.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wq_a[i], i);
            check($sformatf("%s_data%0d", tag, i), wq_d[i], exp_words[i]);
            if (acc_cyc.size() > 4*i + 4)
                check($sformatf("%s_lat%0d", tag, i), wq_c[i] - acc_cyc[4*i+4], 1);
        end
        check({tag, "_done"},  done,       exp_done);
        check({tag, "_error"}, error,      !exp_done);
        check({tag, "_hold"},  cpu_hold,   !exp_done);
        check({tag, "_wcnt"},  word_count, hdr_bad ? 0 : n);
        check({tag, "_ready"}, byte_ready, 1'b0);

        send_byte(8'hA5, 0, 5, ok);
        check({tag, "_ignored"}, ok, 1'b0);
    endtask

    initial begin
        bit ok;
        int n;
        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_outputs("rst");

        // Single-word frame.
        frame = '{8'h01, 8'h8f, 8'h8a, 8'h00, 8'h04, 8'h01};
        run_frame("t1", 0);
        do_reset();

        // Eight-word program.
        words = '{32'h00004820, 32'h8f8a0004, 32'h8f8b0008, 32'h012a4820,
                  32'h216bffff, 32'h11600001, 32'h1000fffc, 32'haf890000};
        build_frame(8'h00);
        run_frame("t2", 0);
        do_reset();

        // Empty frames: good and bad checksum.
        frame = '{8'h00, 8'h00};
        run_frame("t3a", 0);
        do_reset();
        frame = '{8'h00, 8'h5a};
        run_frame("t3b", 0);
        do_reset();

        // Header beyond DEPTH.
        frame = '{8'h21};
        run_frame("t4", 0);
        do_reset();

        // Gaps between bytes, then a bad checksum.
        frame = '{8'h01, 8'h8f, 8'h8a, 8'h00, 8'h04, 8'h01};
        run_frame("t5a", 5);
        do_reset();
        frame = '{8'h01, 8'h8f, 8'h8a, 8'h00, 8'h04, 8'h02};
        run_frame("t5b", 5);
        do_reset();

        // Reset in the middle of the first word.
        wq_a.delete(); wq_d.delete(); wq_c.delete(); acc_cyc.delete();
        frame = '{8'h02, 8'h12, 8'h34, 8'h56};
        foreach (frame[i]) send_byte(frame[i], 0, 40, ok);
        do_reset();
        check_reset_outputs("t6");
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("t6_nowrite", wq_a.size(), 0);
        frame = '{8'h01, 8'h8f, 8'h8a, 8'h00, 8'h04, 8'h01};
        run_frame("t6b", 2);
        do_reset();

        // Random programs, including a full-depth one, some with corrupted checksums.
        for (int r = 0; r < 4; r++) begin
            n = (r == 0) ? 32 : $urandom_range(0, 32);
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom);
            build_frame(($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00);
            run_frame($sformatf("rnd%0d", r), 3);
            do_reset();
        end

        check("done_err_excl", both_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
